// File: rtl/dot_operand_loader.sv
// rtl/dot_operand_loader.sv - serial operand loader and result collector for dotproduct
//
// Accepts operand pairs over a valid/ready stream, assembles two H-element
// vectors, holds them stable while driving a level start to dotproduct, then
// captures the result and offers it on a valid/ready handshake.
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   in_valid_i/in_ready_o     operand pair handshake
//   in_a_i, in_b_i            operand pair for the current element index
//   in_last_i                 marks the final pair of a vector
//   a_vec_o, b_vec_o          assembled vectors, element i at [i*N +: N]
//   start_dot_o               level start to dotproduct
//   dot_result_i, dot_done_i  dotproduct result and completion
//   out_valid_o/out_ready_i   result handshake
//   out_result_o              captured dot product
//   len_err_o                 one-cycle pulse on a vector-length violation
module dot_operand_loader #(
  parameter int Q = 15,
  parameter int N = 32,
  parameter int H = 10
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N-1:0]   in_a_i,
  input  logic [N-1:0]   in_b_i,
  input  logic           in_last_i,
  output logic [N*H-1:0] a_vec_o,
  output logic [N*H-1:0] b_vec_o,
  output logic           start_dot_o,
  input  logic [N-1:0]   dot_result_i,
  input  logic           dot_done_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [N-1:0]   out_result_o,
  output logic           len_err_o
);

  localparam int IW = (H > 1) ? $clog2(H) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(H - 1);

  // Data is passed through untouched; Q only has to describe a sane format.
  if (H < 3 || Q >= N) begin : g_param_check
    $error("dot_operand_loader: need H >= 3 and Q < N");
  end

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic           run_first_q;
  logic           start_dot_q;
  logic           out_valid_q;
  logic           len_err_q;
  logic [N-1:0]   out_result_q;
  logic [N*H-1:0] a_vec_q;
  logic [N*H-1:0] b_vec_q;
  logic           accept;

  // Ready is the only combinational output; held low during reset so no
  // pair can be taken on a reset edge.
  assign in_ready_o = rst_n_i && ((state_q == FILL) || (state_q == DRAIN));
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= FILL;
      idx_q        <= '0;
      run_first_q  <= 1'b0;
      start_dot_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      len_err_q    <= 1'b0;
      out_result_q <= '0;
      a_vec_q      <= '0;
      b_vec_q      <= '0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            a_vec_q[idx_q*N +: N] <= in_a_i;
            b_vec_q[idx_q*N +: N] <= in_b_i;
            if (in_last_i) begin
              idx_q <= '0;
              if (idx_q == LAST_IDX) begin
                state_q     <= RUN;
                start_dot_q <= 1'b1;
                run_first_q <= 1'b1;
              end else begin
                // Short vector: restart filling from element 0.
                len_err_q <= 1'b1;
              end
            end else if (idx_q == LAST_IDX) begin
              // Long vector: swallow the rest up to its in_last.
              len_err_q <= 1'b1;
              idx_q     <= '0;
              state_q   <= DRAIN;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept && in_last_i) begin
            state_q <= FILL;
          end
        end
        RUN: begin
          // A done seen in the first RUN cycle may belong to the previous
          // computation, so it is not honored.
          if (run_first_q) begin
            run_first_q <= 1'b0;
          end else if (dot_done_i) begin
            out_result_q <= dot_result_i;
            start_dot_q  <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign a_vec_o      = a_vec_q;
  assign b_vec_o      = b_vec_q;
  assign start_dot_o  = start_dot_q;
  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_dot_operand_loader.sv
// tb/tb_dot_operand_loader.sv - self-checking bench for dot_operand_loader
module tb_dot_operand_loader;
  localparam int Q = 15;
  localparam int N = 32;
  localparam int H = 10;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   in_a = '0;
  logic [N-1:0]   in_b = '0;
  logic           in_last = 1'b0;
  logic [N*H-1:0] a_vec;
  logic [N*H-1:0] b_vec;
  logic           start_dot;
  logic [N-1:0]   dot_result = '0;
  logic           dot_done = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N-1:0]   out_result;
  logic           len_err;

  dot_operand_loader #(.Q(Q), .N(N), .H(H)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .a_vec_o(a_vec), .b_vec_o(b_vec), .start_dot_o(start_dot),
    .dot_result_i(dot_result), .dot_done_i(dot_done),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
    .len_err_o(len_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] va[16];
  logic [N-1:0] vb[16];
  logic         lst[16];
  logic         len_seen[16];
  logic         start_seen[16];
  logic [31:0]  last_acc_cyc;

  // Downstream dotproduct stand-in: Q-format dot product after LAT cycles,
  // or done tied high with a cycle-stamped result in stale mode.
  bit           tie_done = 1'b0;
  bit           busy = 1'b0;
  int           cnt = 0;
  logic [N-1:0] res = '0;

  function automatic logic [N-1:0] dot_of_vecs(input logic [N*H-1:0] av, input logic [N*H-1:0] bv);
    logic signed [63:0] acc = 0;
    logic signed [63:0] pa, pb;
    for (int i = 0; i < H; i++) begin
      pa = 64'(signed'(av[i*N +: N]));
      pb = 64'(signed'(bv[i*N +: N]));
      acc = acc + ((pa * pb) >>> Q);
    end
    return acc[N-1:0];
  endfunction

  function automatic logic [N-1:0] exp_dot();
    logic signed [63:0] acc = 0;
    logic signed [63:0] pa, pb;
    for (int i = 0; i < H; i++) begin
      pa = 64'(signed'(va[i]));
      pb = 64'(signed'(vb[i]));
      acc = acc + ((pa * pb) >>> Q);
    end
    return acc[N-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      dot_done = 1'b0;
    end else if (tie_done) begin
      dot_done = 1'b1;
      dot_result = cyc;
    end else begin
      dot_done = 1'b0;
      if (busy) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          dot_done = 1'b1;
          dot_result = res;
          busy = 1'b0;
        end
      end else if (start_dot) begin
        busy = 1'b1;
        cnt = LAT;
        res = dot_of_vecs(a_vec, b_vec);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 16; i++) begin
      va[i] = 32'h0000_8000;
      vb[i] = 32'(i) * 32'h0000_4000;
      lst[i] = (i == H - 1);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) begin
      va[i] = $urandom_range(0, 32'h3_FFFF) - 32'h2_0000;
      vb[i] = $urandom_range(0, 32'h3_FFFF) - 32'h2_0000;
      lst[i] = (i == H - 1);
    end
  endtask

  task automatic send_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      int  t;
      bit  rdy;
      @(negedge clk);
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_last = lst[i];
      t = 0;
      rdy = in_ready;
      while (!rdy && t < 200) begin
        @(negedge clk);
        rdy = in_ready;
        t++;
      end
      if (!rdy) begin
        check("accept_timeout", 64'(rdy), 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      last_acc_cyc  = cyc;
      len_seen[i]   = len_err;
      start_seen[i] = start_dot;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int t = 0;
    logic [N-1:0] e;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_result"}, 64'(out_result), 64'(e));
  endtask

  task automatic handshake_done(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_valid_dropped"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int bad;
    logic [N-1:0] held;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_start", 64'(start_dot), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_vecs", 64'(|{a_vec, b_vec}), 64'd0);

    // Nominal: 1.0 * i*0.5 summed over 0..9 = 22.5
    set_nominal();
    exp_q.push_back(exp_dot());
    send_pairs(H);
    check("nom_no_start_early", 64'(start_seen[H-2]), 64'd0);
    check("nom_start_after_last", 64'(start_seen[H-1]), 64'd1);
    check("nom_no_len_err", 64'(len_seen[H-1]), 64'd0);
    check("nom_a9", 64'(a_vec[9*N +: N]), 64'h8000);
    check("nom_b9", 64'(b_vec[9*N +: N]), 64'h2_4000);
    check("nom_b3", 64'(b_vec[3*N +: N]), 64'hC000);
    wait_result("nom");
    check("nom_const", 64'(out_result), 64'h000B_4000);
    handshake_done("nom");

    // Backpressure: result held with in_valid asserted and out_ready low
    set_random();
    out_ready = 1'b0;
    exp_q.push_back(exp_dot());
    send_pairs(H);
    wait_result("bp");
    held = out_result;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_last = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held || start_dot !== 1'b0) bad++;
    end
    check("bp_hold_cycles_bad", 64'(bad), 64'd0);
    @(negedge clk) out_ready = 1'b1;
    handshake_done("bp");
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;

    // Short vector then a correct one
    set_random();
    lst[3] = 1'b1;
    send_pairs(4);
    check("short_len_err", 64'(len_seen[3]), 64'd1);
    check("short_no_start", 64'(start_seen[3]), 64'd0);
    @(posedge clk);
    #1;
    check("short_len_err_1cyc", 64'(len_err), 64'd0);
    check("short_still_no_start", 64'(start_dot), 64'd0);
    set_random();
    exp_q.push_back(exp_dot());
    send_pairs(H);
    wait_result("short_next");
    handshake_done("short_next");

    // Long vector: 13 pairs, last on the 13th
    set_random();
    for (int i = 0; i < 16; i++) lst[i] = (i == 12);
    send_pairs(13);
    check("long_len_err_10th", 64'(len_seen[9]), 64'd1);
    check("long_len_err_pulse", 64'(len_seen[10]), 64'd0);
    check("long_no_start", 64'(start_seen[12]), 64'd0);
    check("long_back_to_fill", 64'(in_ready), 64'd1);
    set_random();
    exp_q.push_back(exp_dot());
    send_pairs(H);
    wait_result("long_next");
    handshake_done("long_next");

    // Stale done: dot_done tied high, result stamped with the cycle count
    set_random();
    tie_done = 1'b1;
    send_pairs(H);
    check("stale_start_t1", 64'(start_seen[H-1]), 64'd1);
    @(posedge clk);
    #1;
    check("stale_start_t2", 64'(start_dot), 64'd1);
    @(posedge clk);
    #1;
    check("stale_start_t3", 64'(start_dot), 64'd0);
    exp_q.push_back(last_acc_cyc + 32'd1);
    wait_result("stale");
    handshake_done("stale");
    @(negedge clk) tie_done = 1'b0;

    // Reset while start_dot is high
    set_random();
    send_pairs(H);
    check("rr_start_high", 64'(start_seen[H-1]), 64'd1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rr_start", 64'(start_dot), 64'd0);
    check("rr_out_valid", 64'(out_valid), 64'd0);
    check("rr_len_err", 64'(len_err), 64'd0);
    check("rr_out_result", 64'(out_result), 64'd0);
    check("rr_vecs", 64'(|{a_vec, b_vec}), 64'd0);
    check("rr_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rr_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || start_dot !== 1'b0) bad++;
    end
    check("rr_no_output", 64'(bad), 64'd0);

    // Recovery after reset
    set_random();
    exp_q.push_back(exp_dot());
    send_pairs(H);
    wait_result("recover");
    handshake_done("recover");
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
